playfield_scan: RTL and testbench

PLAYFIELD_SCAN -- requirements
Module: playfield_scan

---
 rtl/playfield_scan.sv | 198 +++++++++++++++++++
 tb/tb_playfield_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/playfield_scan.sv
// playfield_scan: double-buffered 12-column LED playfield scanner.
// A fetch engine copies ROWS words from RAM port B into a shadow buffer.
// At each frame boundary the shadow is swapped into the display buffer,
// which is scanned one row per DWELL clocks.
module playfield_scan #(
  parameter int ROWS     = 16,
  parameter int ROW_BASE = 0,
  parameter int DWELL    = 1024
) (
  input  logic        Clock,
  input  logic        reset,
  output logic [4:0]  address_b,
  output logic        rden_b,
  input  logic [11:0] q_b,
  input  logic        blank,
  output logic [3:0]  row_sel,
  output logic [11:0] col_out,
  output logic        frame_done
);

  localparam int             DW         = $clog2(DWELL);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0]     ROW_LAST   = 4'(ROWS - 1);
  localparam logic [4:0]     ADDR_FIRST = 5'(ROW_BASE % 32);

  typedef enum logic [1:0] {
    F_IDLE,
    F_ISSUE,
    F_DRAIN,
    F_DONE
  } fetch_state_t;

  // Fetch engine state
  fetch_state_t state_reg, state_next;
  logic [3:0]   idx_reg, idx_next;
  logic [4:0]   addr_reg, addr_next;
  logic         rden_reg, rden_next;
  logic         drain_reg, drain_next;

  // Two-stage (valid, index) tracker matching the RAM read latency
  logic         v1_reg, v2_reg;
  logic [3:0]   i1_reg, i2_reg;

  // Scan and frame bookkeeping
  logic [DW-1:0] dwell_reg;
  logic [3:0]    row_reg;
  logic          frame_done_reg;
  logic          shadow_valid_reg;
  logic          start_reg;

  // Buffers, flattened so each generate row owns a disjoint slice
  logic [ROWS*12-1:0] shadow_flat;
  logic [ROWS*12-1:0] display_flat;

  logic        wrap;
  logic        trigger;
  logic        swap;
  logic [11:0] cur_row;
  logic [11:0] col_rev;

  // Last dwell cycle of the last row: the frame boundary
  assign wrap    = (dwell_reg == DWELL_LAST) && (row_reg == ROW_LAST);
  assign trigger = start_reg | wrap;
  assign swap    = wrap & shadow_valid_reg;

  genvar gi;

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [11:0] shadow_row_reg;
      logic [11:0] display_row_reg;

      // Capture returning RAM data for this row; copy shadow to display on swap
      always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
          shadow_row_reg  <= '0;
          display_row_reg <= '0;
        end else begin
          if (v2_reg && (i2_reg == 4'(gi))) shadow_row_reg <= q_b;
          if (swap) display_row_reg <= shadow_row_reg;
        end
      end

      assign shadow_flat[gi*12 +: 12]  = shadow_row_reg;
      assign display_flat[gi*12 +: 12] = display_row_reg;
    end
  endgenerate

  assign cur_row = display_flat[row_reg*12 +: 12];

  // RAM bit 11 is column 0, so the word is mirrored onto col_out
  generate
    for (gi = 0; gi < 12; gi++) begin : g_col
      assign col_rev[gi] = cur_row[11-gi];
    end
  endgenerate

  // Fetch FSM state register; address/rden are registered so they hold cleanly
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_reg <= F_IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      rden_reg  <= 1'b0;
      drain_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      rden_reg  <= rden_next;
      drain_reg <= drain_next;
    end
  end

  // Fetch FSM next state: issue ROWS reads, wait out the latency, publish
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    rden_next  = 1'b0;
    drain_next = drain_reg;
    case (state_reg)
      F_IDLE: begin
        if (trigger) begin
          state_next = F_ISSUE;
          idx_next   = '0;
          addr_next  = ADDR_FIRST;
          rden_next  = 1'b1;
        end
      end
      F_ISSUE: begin
        if (idx_reg == ROW_LAST) begin
          state_next = F_DRAIN;
          drain_next = 1'b0;
        end else begin
          idx_next  = idx_reg + 4'd1;
          addr_next = addr_reg + 5'd1;
          rden_next = 1'b1;
        end
      end
      F_DRAIN: begin
        if (drain_reg) state_next = F_DONE;
        else drain_next = 1'b1;
      end
      F_DONE: begin
        state_next = F_IDLE;
      end
      default: begin
        state_next = F_IDLE;
      end
    endcase
  end

  // Delay the issued index by the RAM latency so data lands in the right row
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      i1_reg <= '0;
      i2_reg <= '0;
    end else begin
      v1_reg <= rden_reg;
      i1_reg <= idx_reg;
      v2_reg <= v1_reg;
      i2_reg <= i1_reg;
    end
  end

  // Row scan timing, frame swap handshake and the post-reset fetch kick
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      dwell_reg        <= '0;
      row_reg          <= '0;
      frame_done_reg   <= 1'b0;
      shadow_valid_reg <= 1'b0;
      start_reg        <= 1'b1;
    end else begin
      start_reg      <= 1'b0;
      frame_done_reg <= swap;
      if (dwell_reg == DWELL_LAST) begin
        dwell_reg <= '0;
        row_reg   <= (row_reg == ROW_LAST) ? 4'd0 : row_reg + 4'd1;
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
      // A fetch completing wins over a simultaneous swap: its data is newer
      if (state_reg == F_DONE) shadow_valid_reg <= 1'b1;
      else if (swap) shadow_valid_reg <= 1'b0;
    end
  end

  assign address_b  = addr_reg;
  assign rden_b     = rden_reg;
  assign row_sel    = row_reg;
  assign frame_done = frame_done_reg;
  assign col_out    = blank ? 12'h000 : col_rev;

endmodule

// File: tb/tb_playfield_scan.sv
// Bench for playfield_scan (ROWS=16, DWELL=4), with a second instance at ROW_BASE=30.
// Expected outputs come from a frame-level model driven by the cycle count since reset.
module tb_playfield_scan;

  logic        Clock = 1'b0;
  logic        reset;
  logic [4:0]  address_b, address_b30;
  logic        rden_b, rden_b30;
  logic [11:0] q_b = 12'h000;
  logic [11:0] q_b30;
  logic        blank;
  logic [3:0]  row_sel, row_sel30;
  logic [11:0] col_out, col_out30;
  logic        frame_done, frame_done30;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  assign q_b30 = 12'h000;

  playfield_scan #(.ROWS(16), .ROW_BASE(0), .DWELL(4)) dut (
    .Clock(Clock), .reset(reset), .address_b(address_b), .rden_b(rden_b),
    .q_b(q_b), .blank(blank), .row_sel(row_sel), .col_out(col_out),
    .frame_done(frame_done)
  );

  playfield_scan #(.ROWS(16), .ROW_BASE(30), .DWELL(4)) dut30 (
    .Clock(Clock), .reset(reset), .address_b(address_b30), .rden_b(rden_b30),
    .q_b(q_b30), .blank(blank), .row_sel(row_sel30), .col_out(col_out30),
    .frame_done(frame_done30)
  );

  // Playfield RAM, two-cycle read latency
  logic [11:0] mem [32];
  logic [11:0] ram_stage = 12'h000;
  always @(posedge Clock) begin
    if (rden_b) ram_stage <= mem[address_b];
    q_b <= ram_stage;
  end

  // Frame-level reference model
  int          n;
  logic [11:0] disp [16];
  logic [11:0] snap [16];
  bit          snap_ok;
  bit          fd_exp;

  function automatic logic [11:0] rev12(input logic [11:0] w);
    logic [11:0] r;
    for (int c = 0; c < 12; c++) r[c] = w[11-c];
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_clear();
    n       = 0;
    snap_ok = 1'b0;
    fd_exp  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      disp[i] = 12'h000;
      snap[i] = 12'h000;
    end
  endtask

  // One clock edge of the model: frames swap every 64 cycles, a fetch that
  // starts at cycle s has its whole frame captured by cycle s+19
  task automatic model_edge();
    int s;
    n++;
    fd_exp = 1'b0;
    if ((n % 64 == 0) && snap_ok) begin
      for (int i = 0; i < 16; i++) disp[i] = snap[i];
      snap_ok = 1'b0;
      fd_exp  = 1'b1;
      $display("frame swapped at cycle %0d", n);
    end
    s = (n < 64) ? 1 : (n / 64) * 64;
    if (n == s + 19) begin
      for (int i = 0; i < 16; i++) snap[i] = mem[i];
      snap_ok = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int s, o, erow;
    logic        er;
    logic [4:0]  ea, ea30;
    logic [11:0] ecol;
    if (n == 0) begin
      er = 1'b0; ea = 5'd0; ea30 = 5'd0;
    end else begin
      s    = (n < 64) ? 1 : (n / 64) * 64;
      o    = n - s;
      er   = (o < 16);
      if (o > 15) o = 15;
      ea   = 5'(o % 32);
      ea30 = 5'((30 + o) % 32);
    end
    erow = (n / 4) % 16;
    ecol = blank ? 12'h000 : rev12(disp[erow]);
    check_val("rden_b", 32'(rden_b), 32'(er));
    check_val("address_b", 32'(address_b), 32'(ea));
    check_val("row_sel", 32'(row_sel), 32'(erow));
    check_val("col_out", 32'(col_out), 32'(ecol));
    check_val("frame_done", 32'(frame_done), 32'(fd_exp));
    check_val("rden_b30", 32'(rden_b30), 32'(er));
    check_val("address_b30", 32'(address_b30), 32'(ea30));
    check_val("row_sel30", 32'(row_sel30), 32'(erow));
    check_val("col_out30", 32'(col_out30), 32'h0);
    check_val("frame_done30", 32'(frame_done30), 32'(fd_exp));
  endtask

  task automatic tick(input bit rand_mode);
    @(posedge Clock);
    #1;
    model_edge();
    if (rand_mode) begin
      blank = ($urandom_range(0, 3) == 0);
      if (n % 64 == 40)
        for (int i = 0; i < 16; i++) mem[i] = 12'($urandom);
    end
    #2;
    check_outputs();
  endtask

  initial begin
    reset = 1'b0;
    blank = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
    mem[3] = 12'h800;
    model_clear();

    // Held in reset: everything reads zero
    repeat (3) begin
      @(posedge Clock);
      #3;
      check_outputs();
    end
    #1 reset = 1'b1;

    // Single lit pixel, no blanking, two full frames
    repeat (140) tick(1'b0);

    // Random blanking and RAM rewrites between fetches
    repeat (400) tick(1'b1);

    // Run into the middle of a fetch, then pull reset
    for (int k = 0; k < 64; k++) begin
      if ((n % 64 == 8) && (n > 64)) break;
      tick(1'b1);
    end
    #1;
    blank = 1'b0;
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (3) begin
      @(posedge Clock);
      #3;
      check_outputs();
    end
    #1 reset = 1'b1;

    repeat (200) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
